// File: rtl/mem_req_matching_bridge_if.sv
// Bundle of requester, memory and response signals for mem_req_matching_bridge.
// The master modport is the bridge's view; slave is the surrounding system's view.
interface mem_req_matching_bridge_if #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned WDW     = 32,
  parameter int unsigned RDW     = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DEPTH_N = 2
);

  logic                  iFLUSH;
  logic [N_CH-1:0]       iREQ_VALID;
  logic [N_CH-1:0]       oREQ_LOCK;
  logic [N_CH-1:0]       iREQ_RW;
  logic [N_CH*AW-1:0]    iREQ_ADDR;
  logic [N_CH*WDW-1:0]   iREQ_DATA;
  logic                  oMEM_REQ;
  logic                  iMEM_LOCK;
  logic                  oMEM_RW;
  logic [AW-1:0]         oMEM_ADDR;
  logic [WDW-1:0]        oMEM_DATA;
  logic                  iMEM_VALID;
  logic                  oMEM_BUSY;
  logic [RDW-1:0]        iMEM_DATA;
  logic [N_CH-1:0]       oRSP_VALID;
  logic [N_CH-1:0]       iRSP_BUSY;
  logic [RDW-1:0]        oRSP_DATA;
  logic [DEPTH_N:0]      oOUTSTANDING;

  modport master (
    input  iFLUSH, iREQ_VALID, iREQ_RW, iREQ_ADDR, iREQ_DATA,
    input  iMEM_LOCK, iMEM_VALID, iMEM_DATA, iRSP_BUSY,
    output oREQ_LOCK, oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_DATA,
    output oMEM_BUSY, oRSP_VALID, oRSP_DATA, oOUTSTANDING
  );

  modport slave (
    output iFLUSH, iREQ_VALID, iREQ_RW, iREQ_ADDR, iREQ_DATA,
    output iMEM_LOCK, iMEM_VALID, iMEM_DATA, iRSP_BUSY,
    input  oREQ_LOCK, oMEM_REQ, oMEM_RW, oMEM_ADDR, oMEM_DATA,
    input  oMEM_BUSY, oRSP_VALID, oRSP_DATA, oOUTSTANDING
  );

endinterface

// File: rtl/mem_req_matching_bridge.sv
// Multi-channel memory request bridge: round-robin arbitration of N_CH requesters onto a
// single registered memory port, with an in-order owner FIFO that routes read returns
// back to the issuing channel. Flush drops every response still owed at flush time.
module mem_req_matching_bridge #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned WDW     = 32,
  parameter int unsigned RDW     = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DEPTH_N = 2
) (
  input logic                    iCLOCK,
  input logic                    inRESET,
  mem_req_matching_bridge_if.master bus
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [DEPTH_N:0] DepthCnt = (DEPTH_N + 1)'(DEPTH);
  localparam logic [CH_W-1:0] LastCh = CH_W'(N_CH - 1);

  // Output stage
  logic            mem_req_q;
  logic            mem_rw_q;
  logic [AW-1:0]   mem_addr_q;
  logic [WDW-1:0]  mem_data_q;

  // Arbitration and owner tracking
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [CH_W-1:0]    owner_q [DEPTH];
  logic [DEPTH_N-1:0] wptr_q, rptr_q;
  logic [DEPTH_N:0]   count_q, count_d;
  logic [DEPTH_N:0]   drop_q, drop_d;

  logic [AW-1:0]   req_addr [N_CH];
  logic [WDW-1:0]  req_data [N_CH];

  logic            stage_free;
  logic            fifo_full;
  logic            found;
  logic            grant;
  logic [CH_W-1:0] gidx;
  logic            push;
  logic [CH_W-1:0] head;
  logic            dropping;
  logic            pop;
  logic            rsp_fire;

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign req_addr[c] = bus.iREQ_ADDR[c*AW +: AW];
    assign req_data[c] = bus.iREQ_DATA[c*WDW +: WDW];
  end

  assign stage_free = !mem_req_q || !bus.iMEM_LOCK;
  assign fifo_full  = (count_q == DepthCnt);

  // Round-robin search starting at rr_q; reads are ineligible while the owner FIFO is full
  always_comb begin
    int idx;
    logic [CH_W-1:0] cidx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    cidx  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      idx = int'(rr_q) + i;
      if (idx >= int'(N_CH)) idx = idx - int'(N_CH);
      cidx = CH_W'(idx);
      if (!found && bus.iREQ_VALID[cidx] && (!bus.iREQ_RW[cidx] || !fifo_full)) begin
        found = 1'b1;
        gidx  = cidx;
      end
    end
  end

  assign grant = found && stage_free;
  assign push  = grant && bus.iREQ_RW[gidx];
  assign rr_d  = (gidx == LastCh) ? '0 : gidx + 1'b1;

  // Response side: head owner decides routing; dropped returns ignore backpressure
  assign head     = owner_q[rptr_q];
  assign dropping = (drop_q != '0);
  assign pop      = bus.iMEM_VALID && (count_q != '0) && (dropping || !bus.iRSP_BUSY[head]);
  assign rsp_fire = pop && !dropping;

  // Occupancy and drop counters; a same-cycle grant is never part of the drop set
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    drop_d = drop_q;
    if (bus.iFLUSH)           drop_d = count_q - {{DEPTH_N{1'b0}}, pop};
    else if (dropping && pop) drop_d = drop_q - 1'b1;
  end

  // Per-channel lock, response strobe and remaining outputs
  always_comb begin
    bus.oREQ_LOCK  = '1;
    bus.oRSP_VALID = '0;
    if (grant && inRESET) bus.oREQ_LOCK[gidx] = 1'b0;
    if (rsp_fire)         bus.oRSP_VALID[head] = 1'b1;
  end

  assign bus.oRSP_DATA    = bus.iMEM_DATA;
  assign bus.oMEM_BUSY    = bus.iRSP_BUSY[head] && !dropping;
  assign bus.oMEM_REQ     = mem_req_q;
  assign bus.oMEM_RW      = mem_rw_q;
  assign bus.oMEM_ADDR    = mem_addr_q;
  assign bus.oMEM_DATA    = mem_data_q;
  assign bus.oOUTSTANDING = count_q;

  // Output stage loads on grant, empties when accepted with nothing new to send
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      mem_req_q  <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rr_q       <= '0;
    end else if (grant) begin
      mem_req_q  <= 1'b1;
      mem_rw_q   <= bus.iREQ_RW[gidx];
      mem_addr_q <= req_addr[gidx];
      mem_data_q <= req_data[gidx];
      rr_q       <= rr_d;
    end else if (stage_free) begin
      mem_req_q  <= 1'b0;
    end
  end

  // Owner FIFO and counters; pointers wrap naturally at DEPTH
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < int'(DEPTH); i++) owner_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) begin
        owner_q[wptr_q] <= gidx;
        wptr_q          <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // A return with nothing outstanding is a memory-side protocol error
  a_no_orphan_return: assert property (@(posedge iCLOCK) disable iff (!inRESET)
    !(bus.iMEM_VALID && (count_q == '0)))
    else $error("mem_req_matching_bridge: read return with no outstanding read");

endmodule

// File: tb/tb_mem_req_matching_bridge.sv
// Directed bench for mem_req_matching_bridge (2 channels, depth 4).
module tb_mem_req_matching_bridge;

  localparam int unsigned N_CH = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned WDW = 32;
  localparam int unsigned RDW = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DEPTH_N = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mem_req_matching_bridge_if #(
    .N_CH(N_CH), .AW(AW), .WDW(WDW), .RDW(RDW), .DEPTH(DEPTH), .DEPTH_N(DEPTH_N)
  ) bus ();

  mem_req_matching_bridge #(
    .N_CH(N_CH), .AW(AW), .WDW(WDW), .RDW(RDW), .DEPTH(DEPTH), .DEPTH_N(DEPTH_N)
  ) dut (
    .iCLOCK (clk),
    .inRESET(rst_n),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.iFLUSH     = 1'b0;
    bus.iREQ_VALID = '0;
    bus.iREQ_RW    = '0;
    bus.iREQ_ADDR  = '0;
    bus.iREQ_DATA  = '0;
    bus.iMEM_LOCK  = 1'b0;
    bus.iMEM_VALID = 1'b0;
    bus.iMEM_DATA  = '0;
    bus.iRSP_BUSY  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    settle();
    check_eq("rst_lock", 64'(bus.oREQ_LOCK), 64'h3);
    check_eq("rst_mem_req", 64'(bus.oMEM_REQ), 64'h0);
    check_eq("rst_rsp_valid", 64'(bus.oRSP_VALID), 64'h0);
    check_eq("rst_outstanding", 64'(bus.oOUTSTANDING), 64'h0);
    tick();
    rst_n = 1'b1;
  endtask

  // Issue one read per cycle from the listed channels, then let the stage drain
  task automatic issue_reads(input logic [1:0] chs [4], input int n);
    for (int i = 0; i < n; i++) begin
      bus.iREQ_VALID = '0;
      bus.iREQ_RW    = 2'b11;
      bus.iREQ_VALID[chs[i]] = 1'b1;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    logic [1:0]  seq [4];
    logic [63:0] dat [4];
    n_cmp = 0;
    n_err = 0;
    idle_inputs();

    // Single read on ch0 and its return
    do_reset();
    bus.iREQ_VALID = 2'b01;
    bus.iREQ_RW    = 2'b01;
    bus.iREQ_ADDR  = {32'h0, 32'h100};
    settle();
    check_eq("t1_lock", 64'(bus.oREQ_LOCK), 64'h2);
    tick();
    idle_inputs();
    check_eq("t1_mem_req", 64'(bus.oMEM_REQ), 64'h1);
    check_eq("t1_mem_addr", 64'(bus.oMEM_ADDR), 64'h100);
    check_eq("t1_mem_rw", 64'(bus.oMEM_RW), 64'h1);
    check_eq("t1_outst", 64'(bus.oOUTSTANDING), 64'h1);
    tick();
    check_eq("t1_mem_req_drop", 64'(bus.oMEM_REQ), 64'h0);
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = 64'hDEAD;
    settle();
    check_eq("t1_rsp_valid", 64'(bus.oRSP_VALID), 64'h1);
    check_eq("t1_rsp_data", 64'(bus.oRSP_DATA), 64'hDEAD);
    check_eq("t1_busy", 64'(bus.oMEM_BUSY), 64'h0);
    tick();
    idle_inputs();
    check_eq("t1_outst_end", 64'(bus.oOUTSTANDING), 64'h0);

    // Both channels read every cycle: alternate grants until the FIFO fills
    do_reset();
    bus.iREQ_VALID = 2'b11;
    bus.iREQ_RW    = 2'b11;
    bus.iREQ_ADDR  = {32'h300, 32'h200};
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq($sformatf("t2_lock%0d", i), 64'(bus.oREQ_LOCK), (i % 2 == 0) ? 64'h2 : 64'h1);
      tick();
      check_eq($sformatf("t2_addr%0d", i), 64'(bus.oMEM_ADDR),
               (i % 2 == 0) ? 64'h200 : 64'h300);
      check_eq($sformatf("t2_outst%0d", i), 64'(bus.oOUTSTANDING), 64'(i + 1));
    end
    settle();
    check_eq("t2_full_lock", 64'(bus.oREQ_LOCK), 64'h3);
    tick();
    check_eq("t2_full_mem_req", 64'(bus.oMEM_REQ), 64'h0);
    check_eq("t2_full_outst", 64'(bus.oOUTSTANDING), 64'h4);
    idle_inputs();

    // Four reads from ch0,1,1,0 return in order to their owners
    do_reset();
    seq = '{2'd0, 2'd1, 2'd1, 2'd0};
    dat = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
    issue_reads(seq, 4);
    check_eq("t3_outst_full", 64'(bus.oOUTSTANDING), 64'h4);
    for (int i = 0; i < 4; i++) begin
      bus.iMEM_VALID = 1'b1;
      bus.iMEM_DATA  = dat[i];
      settle();
      check_eq($sformatf("t3_strobe%0d", i), 64'(bus.oRSP_VALID), (seq[i] == 2'd0) ? 64'h1 : 64'h2);
      check_eq($sformatf("t3_data%0d", i), 64'(bus.oRSP_DATA), dat[i]);
      tick();
      check_eq($sformatf("t3_outst%0d", i), 64'(bus.oOUTSTANDING), 64'(3 - i));
    end
    idle_inputs();

    // Flush with three outstanding and a same-cycle ch1 read
    do_reset();
    seq = '{2'd0, 2'd0, 2'd0, 2'd0};
    issue_reads(seq, 3);
    bus.iFLUSH     = 1'b1;
    bus.iREQ_VALID = 2'b10;
    bus.iREQ_RW    = 2'b10;
    settle();
    check_eq("t4_lock", 64'(bus.oREQ_LOCK), 64'h1);
    tick();
    idle_inputs();
    check_eq("t4_outst", 64'(bus.oOUTSTANDING), 64'h4);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.iMEM_VALID = 1'b1;
      bus.iMEM_DATA  = 64'hF0 + 64'(i);
      settle();
      check_eq($sformatf("t4_strobe%0d", i), 64'(bus.oRSP_VALID), (i == 3) ? 64'h2 : 64'h0);
      tick();
    end
    idle_inputs();
    check_eq("t4_outst_end", 64'(bus.oOUTSTANDING), 64'h0);

    // Memory lock holds the stage; pending write waits, then is granted
    do_reset();
    bus.iMEM_LOCK  = 1'b1;
    bus.iREQ_VALID = 2'b01;
    bus.iREQ_ADDR  = {32'h600, 32'h500};
    bus.iREQ_DATA  = {32'h5678, 32'h1234};
    settle();
    check_eq("t5_first_lock", 64'(bus.oREQ_LOCK), 64'h2);
    tick();
    bus.iREQ_VALID = 2'b10;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq($sformatf("t5_lock%0d", i), 64'(bus.oREQ_LOCK), 64'h3);
      check_eq($sformatf("t5_req%0d", i), 64'(bus.oMEM_REQ), 64'h1);
      check_eq($sformatf("t5_addr%0d", i), 64'(bus.oMEM_ADDR), 64'h500);
      check_eq($sformatf("t5_data%0d", i), 64'(bus.oMEM_DATA), 64'h1234);
      tick();
    end
    bus.iMEM_LOCK = 1'b0;
    settle();
    check_eq("t5_release_lock", 64'(bus.oREQ_LOCK), 64'h1);
    tick();
    idle_inputs();
    check_eq("t5_addr_next", 64'(bus.oMEM_ADDR), 64'h600);
    check_eq("t5_data_next", 64'(bus.oMEM_DATA), 64'h5678);
    check_eq("t5_rw_next", 64'(bus.oMEM_RW), 64'h0);
    check_eq("t5_outst", 64'(bus.oOUTSTANDING), 64'h0);

    // Response backpressure on the head owner stalls the return
    do_reset();
    seq = '{2'd0, 2'd0, 2'd0, 2'd0};
    issue_reads(seq, 1);
    bus.iRSP_BUSY  = 2'b01;
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = 64'hBEEF;
    settle();
    check_eq("t6_busy", 64'(bus.oMEM_BUSY), 64'h1);
    tick();
    check_eq("t6_no_pop", 64'(bus.oOUTSTANDING), 64'h1);
    bus.iRSP_BUSY = 2'b00;
    settle();
    check_eq("t6_busy_clear", 64'(bus.oMEM_BUSY), 64'h0);
    check_eq("t6_strobe", 64'(bus.oRSP_VALID), 64'h1);
    check_eq("t6_data", 64'(bus.oRSP_DATA), 64'hBEEF);
    tick();
    idle_inputs();
    check_eq("t6_pop", 64'(bus.oOUTSTANDING), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
